// File: rtl/gnr_floyd_ctrl.sv
// Run controller for a dual-trajectory Boolean gene network: loads each initial state,
// steps tortoise/hare until Floyd match or step limit, and streams one result per run.
module gnr_floyd_ctrl #(
  parameter int unsigned N_NODES   = 188,
  parameter int unsigned STEP_W    = 24,
  parameter int unsigned RUN_W     = 16,
  parameter int unsigned MAX_STEPS = 2**20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RUN_W-1:0]   num_runs,
  input  logic [N_NODES-1:0] init_base,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RUN_W-1:0]   res_run,
  output logic [STEP_W-1:0]  res_steps,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  localparam logic [STEP_W-1:0] MaxStepCnt = STEP_W'(MAX_STEPS);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StOut, StDone} state_e;

  state_e               state_q, state_d;
  logic [RUN_W-1:0]     num_runs_q, num_runs_d;
  logic [RUN_W-1:0]     run_idx_q, run_idx_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0]    res_steps_q, res_steps_d;
  logic                 res_timeout_q, res_timeout_d;
  logic                 busy_q, busy_d;
  logic [N_NODES-1:0]   init_q, init_d;
  logic                 match;
  logic                 at_limit;
  logic                 last_run;

  // Step 0 is excluded: both trajectories are equal straight after a load.
  assign match    = (s0_vec == s1_vec) && (step_cnt_q != '0);
  assign at_limit = (step_cnt_q == MaxStepCnt);
  assign last_run = (run_idx_q == num_runs_q - RUN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      num_runs_q    <= '0;
      run_idx_q     <= '0;
      step_cnt_q    <= '0;
      res_steps_q   <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      init_q        <= '0;
    end else begin
      state_q       <= state_d;
      num_runs_q    <= num_runs_d;
      run_idx_q     <= run_idx_d;
      step_cnt_q    <= step_cnt_d;
      res_steps_q   <= res_steps_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
      init_q        <= init_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    num_runs_d    = num_runs_q;
    run_idx_d     = run_idx_q;
    step_cnt_d    = step_cnt_q;
    res_steps_d   = res_steps_q;
    res_timeout_d = res_timeout_q;
    busy_d        = busy_q;
    init_d        = init_q;
    reset_nos     = 1'b0;
    start_s0      = 1'b0;
    start_s1      = 1'b0;
    res_valid     = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_runs_d = num_runs;
          init_d     = init_base;
          run_idx_d  = '0;
          busy_d     = 1'b1;
          state_d    = (num_runs == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        reset_nos  = 1'b1;
        step_cnt_d = '0;
        state_d    = StRun;
      end
      StRun: begin
        if (match) begin
          res_steps_d   = step_cnt_q;
          res_timeout_d = 1'b0;
          state_d       = StOut;
        end else if (at_limit) begin
          res_steps_d   = step_cnt_q;
          res_timeout_d = 1'b1;
          state_d       = StOut;
        end else begin
          start_s0   = 1'b1;
          start_s1   = 1'b1;
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      StOut: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (last_run) begin
            state_d = StDone;
          end else begin
            // init_state tracks init_base + run_idx incrementally.
            run_idx_d = run_idx_q + RUN_W'(1);
            init_d    = init_q + N_NODES'(1);
            state_d   = StLoad;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign init_state  = init_q;
  assign res_run     = run_idx_q;
  assign res_steps   = res_steps_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gnr_floyd_ctrl.sv
// Bench for gnr_floyd_ctrl: a behavioural node network drives s0/s1, and each result is
// compared with a Floyd reference computed by iterating the network map directly.
module tb_gnr_floyd_ctrl;

  localparam int unsigned N     = 188;
  localparam int unsigned SW    = 24;
  localparam int unsigned RW    = 16;
  localparam int unsigned MaxSt = 16;

  logic          clk = 1'b0;
  logic          rst, start, res_ready;
  logic [RW-1:0] num_runs;
  logic [N-1:0]  init_base, s0_vec, s1_vec, init_state;
  logic          reset_nos, start_s0, start_s1, res_valid, res_timeout, busy, done;
  logic [RW-1:0] res_run;
  logic [SW-1:0] res_steps;

  gnr_floyd_ctrl #(
    .N_NODES  (N),
    .STEP_W   (SW),
    .RUN_W    (RW),
    .MAX_STEPS(MaxSt)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_runs   (num_runs),
    .init_base  (init_base),
    .s0_vec     (s0_vec),
    .s1_vec     (s1_vec),
    .reset_nos  (reset_nos),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .init_state (init_state),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_run    (res_run),
    .res_steps  (res_steps),
    .res_timeout(res_timeout),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Network map selection: 0 fixed point, 1 3-bit ring, 2 never-equal, 3 counter mod net_m.
  int net_mode = 0;
  int net_m    = 1;

  function automatic logic [N-1:0] f(input logic [N-1:0] x);
    logic [N-1:0] y;
    y = x;
    case (net_mode)
      1:       y[2:0] = {x[1:0], x[2]};
      3:       y[7:0] = 8'((int'(x[7:0]) + 1) % net_m);
      default: ;
    endcase
    return y;
  endfunction

  // Node array model: tortoise moves on odd start_s0 pulses after a load, hare on every pulse.
  logic [N-1:0] s0_q, s1_q;
  logic         pass_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q   <= '0;
      s1_q   <= '0;
      pass_q <= 1'b0;
    end else if (reset_nos) begin
      s0_q   <= init_state;
      s1_q   <= init_state;
      pass_q <= 1'b1;
    end else begin
      if (start_s0) begin
        pass_q <= ~pass_q;
        if (pass_q) s0_q <= f(s0_q);
      end
      if (start_s1) s1_q <= f(s1_q);
    end
  end
  assign s0_vec = s0_q;
  assign s1_vec = (net_mode == 2) ? ~s1_q : s1_q;

  // After k pulses the tortoise has taken ceil(k/2) steps and the hare k steps.
  function automatic void ref_run(input logic [N-1:0] x0, output int steps, output bit to);
    logic [N-1:0] t, h;
    t = x0;
    h = x0;
    steps = MaxSt;
    to = 1'b1;
    for (int k = 1; k <= int'(MaxSt); k++) begin
      h = f(h);
      if (k % 2 == 1) t = f(t);
      if (net_mode != 2 && t == h) begin
        steps = k;
        to = 1'b0;
        return;
      end
    end
  endfunction

  function automatic logic [N-1:0] rnd_vec();
    logic [N-1:0] v;
    for (int i = 0; i < int'(N); i++) v[i] = 1'($urandom);
    return v;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            mode;
    int            m;
    logic [RW-1:0] nr;
    logic [N-1:0]  base;
    int            hold;
    int            exp_steps;  // -1: take expectation from the reference model
    bit            exp_to;
  } vec_t;

  vec_t vecs[11];

  task automatic run_batch(input vec_t v);
    int            steps, pulses, cyc;
    bit            to, bad, ok;
    logic [RW-1:0] c_run;
    logic [SW-1:0] c_steps;
    logic          c_to;
    net_mode  = v.mode;
    net_m     = v.m;
    start     = 1'b1;
    num_runs  = v.nr;
    init_base = v.base;
    step();
    start     = 1'b0;
    num_runs  = RW'($urandom);
    init_base = rnd_vec();
    chk("busy_after_start", N'(busy), N'(1));
    if (v.nr == 0) begin
      chk("zero_done", N'(done), N'(1));
      chk("zero_strobes", N'({reset_nos, start_s0, start_s1, res_valid}), '0);
      step();
      chk("zero_done_once", N'(done), '0);
      chk("zero_busy_clear", N'(busy), '0);
      chk("zero_no_valid", N'(res_valid), '0);
      return;
    end
    for (int r = 0; r < int'(v.nr); r++) begin
      chk("load_strobe", N'(reset_nos), N'(1));
      chk("load_init", init_state, v.base + N'(r));
      chk("load_no_pulse", N'(start_s0 | start_s1), '0);
      step();
      pulses = 0;
      cyc    = 0;
      bad    = 1'b0;
      while (!res_valid && cyc < 100) begin
        if (start_s0) pulses++;
        if (start_s0 !== start_s1 || reset_nos) bad = 1'b1;
        res_ready = 1'($urandom);
        start     = 1'($urandom);
        num_runs  = RW'($urandom);
        cyc++;
        step();
      end
      res_ready = 1'b0;
      start     = 1'b0;
      if (cyc >= 100) begin
        tests++;
        fails++;
        $display("FAIL run_guard: no result after %0d cycles, required within 100", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "result never arrived");
      end
      if (v.exp_steps >= 0) begin
        steps = v.exp_steps;
        to    = v.exp_to;
      end else begin
        ref_run(v.base + N'(r), steps, to);
      end
      chk("res_run", N'(res_run), N'(r));
      chk("res_steps", N'(res_steps), N'(steps));
      chk("res_timeout", N'(res_timeout), N'(to));
      chk("pulse_count", N'(pulses), N'(steps));
      chk("run_cycles", N'(cyc), N'(steps + 1));
      chk("run_strobes", N'(bad), '0);
      chk("out_no_strobe", N'({reset_nos, start_s0, start_s1}), '0);
      c_run   = res_run;
      c_steps = res_steps;
      c_to    = res_timeout;
      ok      = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        step();
        if (!res_valid || res_run !== c_run || res_steps !== c_steps || res_timeout !== c_to ||
            reset_nos || start_s0 || start_s1) ok = 1'b0;
      end
      if (v.hold > 0) chk("out_hold_stable", N'(ok), N'(1));
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
    chk("done_pulse", N'(done), N'(1));
    chk("done_no_valid", N'(res_valid), '0);
    step();
    chk("done_once", N'(done), '0);
    chk("busy_clear", N'(busy), '0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, cyc;
    rst       = 1'b1;
    start     = 1'b0;
    res_ready = 1'b0;
    num_runs  = '0;
    init_base = '0;
    step();
    step();
    chk("rst_strobes", N'({reset_nos, start_s0, start_s1, res_valid, done, busy, res_timeout}),
        '0);
    chk("rst_init", init_state, '0);
    chk("rst_res", N'({res_run, res_steps}), '0);
    rst = 1'b0;
    step();

    vecs[0] = '{mode: 0, m: 1, nr: RW'(1), base: '0, hold: 0, exp_steps: 1, exp_to: 1'b0};
    vecs[1] = '{mode: 1, m: 1, nr: RW'(4), base: N'(5), hold: 0, exp_steps: -1, exp_to: 1'b0};
    vecs[2] = '{mode: 2, m: 1, nr: RW'(1), base: rnd_vec(), hold: 0, exp_steps: int'(MaxSt),
                exp_to: 1'b1};
    vecs[3] = '{mode: 3, m: 5, nr: RW'(2), base: rnd_vec(), hold: 10, exp_steps: -1,
                exp_to: 1'b0};
    vecs[4] = '{mode: 0, m: 1, nr: RW'(0), base: rnd_vec(), hold: 0, exp_steps: -1,
                exp_to: 1'b0};
    for (int i = 5; i < 11; i++) begin
      vecs[i] = '{mode: 3, m: int'($urandom_range(1, 12)), nr: RW'($urandom_range(1, 3)),
                  base: rnd_vec(), hold: int'($urandom_range(0, 3)), exp_steps: -1,
                  exp_to: 1'b0};
    end

    for (int i = 0; i < 11; i++) run_batch(vecs[i]);

    // Reset in the middle of a run at step 7, then restart from run 0.
    net_mode  = 2;
    start     = 1'b1;
    num_runs  = RW'(3);
    init_base = rnd_vec();
    step();
    start = 1'b0;
    step();
    pulses = 0;
    cyc    = 0;
    while (pulses < 7 && cyc < 30) begin
      if (start_s0) pulses++;
      cyc++;
      step();
    end
    chk("mid_reset_reach_step7", N'(pulses), N'(7));
    rst = 1'b1;
    step();
    chk("mid_rst_strobes",
        N'({reset_nos, start_s0, start_s1, res_valid, done, busy, res_timeout}), '0);
    chk("mid_rst_init", init_state, '0);
    chk("mid_rst_res", N'({res_run, res_steps}), '0);
    rst = 1'b0;
    step();
    step();
    chk("mid_rst_idle", N'({reset_nos, start_s0, res_valid, done, busy}), '0);
    run_batch('{mode: 1, m: 1, nr: RW'(2), base: rnd_vec(), hold: 1, exp_steps: -1,
                exp_to: 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
